// File: rtl/uart_tx_frame_if.sv
// Upstream word handshake for the UART transmit framer.
// The master offers a word plus parity settings; the framer reports busy.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  busy;

    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_typ,
        input  busy
    );

    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_typ,
        output busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer, one clk per bit: start, data LSB first,
// optional even/odd parity, stop. Line idles high.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_frame_if.slave bus,
    output logic           tx_out
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_par_en;
    logic                  r_par;
    logic                  r_tx;
    logic                  w_busy;
    logic                  w_accept;

    assign w_busy = (r_state == START) ||
                    (r_state == DATA)  ||
                    (r_state == PARITY);
    assign w_accept = bus.data_valid && !w_busy;
    assign bus.busy = w_busy;
    assign tx_out   = r_tx;

    // r_par starts at par_typ and folds in each bit as it leaves,
    // so it holds the parity bit once the last data bit is out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE, STOP: begin
                    if (w_accept) begin
                        r_state  <= START;
                        r_tx     <= 1'b0;
                        r_shift  <= bus.p_data;
                        r_par_en <= bus.par_en;
                        r_par    <= bus.par_typ;
                    end else begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                    end
                end
                START: begin
                    r_state <= DATA;
                    r_cnt   <= '0;
                    r_tx    <= r_shift[0];
                    r_par   <= r_par ^ r_shift[0];
                    r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
                end
                DATA: begin
                    if (r_cnt == LAST_BIT) begin
                        r_state <= r_par_en ? PARITY : STOP;
                        r_tx    <= r_par_en ? r_par : 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_tx    <= r_shift[0];
                        r_par   <= r_par ^ r_shift[0];
                        r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
                    end
                end
                PARITY: begin
                    r_state <= STOP;
                    r_tx    <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed frames plus random frames
// compared bit by bit against a frame model built from the word.
module tb_uart_tx_frame;
    localparam int DW = 8;

    logic clk;
    logic rst;
    logic tx_out;

    uart_tx_frame_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_frame #(.DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .tx_out (tx_out)
    );

    int vectors     = 0;
    int miscompares = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Line value k cycles after the accept edge.
    function automatic logic exp_bit(input logic [7:0] d, input logic pe,
                                     input logic pt, input int k);
        logic odd_ones;
        odd_ones = (($countones(d) % 2) == 1);
        if (k == 0) return 1'b0;
        if (k <= DW) return d[k-1];
        if (pe && k == DW + 1) return odd_ones ^ pt;
        return 1'b1;
    endfunction

    task automatic scramble();
        bus.p_data  = 8'($urandom);
        bus.par_en  = 1'($urandom_range(0, 1));
        bus.par_typ = 1'($urandom_range(0, 1));
    endtask

    task automatic check_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "/tx"}, tx_out, 1'b1);
            chk({tag, "/busy"}, bus.busy, 1'b0);
        end
    endtask

    task automatic accept(input logic [7:0] d, input logic pe, input logic pt);
        bus.p_data     = d;
        bus.par_en     = pe;
        bus.par_typ    = pt;
        bus.data_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input logic [7:0] d, input logic pe,
                               input logic pt, input string tag,
                               input int poke, input int rst_at);
        int len;
        len = DW + 2 + int'(pe);
        for (int k = 0; k < len; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("%s/tx%0d", tag, k), tx_out, exp_bit(d, pe, pt, k));
            chk($sformatf("%s/busy%0d", tag, k), bus.busy, (k < len - 1));
            if (k == poke) begin
                bus.data_valid = 1'b1;
                bus.p_data     = 8'h55;
                bus.par_en     = ~pe;
                bus.par_typ    = ~pt;
            end
            if (poke >= 0 && k == poke + 1) bus.data_valid = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk({tag, "/async_tx"}, tx_out, 1'b1);
                chk({tag, "/async_busy"}, bus.busy, 1'b0);
                return;
            end
        end
    endtask

    initial begin
        logic [7:0] pw [4];
        logic       pt [4];
        logic [7:0] d;
        logic       pe;
        logic       ty;
        int         gap;

        pw = '{8'hA5, 8'hA5, 8'h01, 8'h07};
        pt = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        bus.data_valid = 1'($urandom_range(0, 1));
        scramble();
        #1;
        chk("reset/tx", tx_out, 1'b1);
        chk("reset/busy", bus.busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold/tx", tx_out, 1'b1);
        chk("reset_hold/busy", bus.busy, 1'b0);
        bus.data_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.data_valid = 1'b0;
        check_idle(3, "rst_rel");

        accept(8'hA5, 1'b0, 1'b0);
        bus.data_valid = 1'b0;
        scramble();
        check_frame(8'hA5, 1'b0, 1'b0, "a5", -1, -1);
        check_idle(2, "a5_idle");

        for (int i = 0; i < 4; i++) begin
            accept(pw[i], 1'b1, pt[i]);
            bus.data_valid = 1'b0;
            scramble();
            check_frame(pw[i], 1'b1, pt[i], $sformatf("par%0d", i), -1, -1);
            check_idle(1, "par_idle");
        end

        accept(8'h3C, 1'b0, 1'b0);
        bus.p_data = 8'hFF;
        check_frame(8'h3C, 1'b0, 1'b0, "b2b0", -1, -1);
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        scramble();
        check_frame(8'hFF, 1'b0, 1'b0, "b2b1", -1, -1);
        check_idle(3, "b2b_idle");

        accept(8'h0F, 1'b1, 1'b0);
        bus.data_valid = 1'b0;
        check_frame(8'h0F, 1'b1, 1'b0, "ign", 3, -1);
        check_idle(3, "ign_idle");

        accept(8'h81, 1'b0, 1'b0);
        bus.data_valid = 1'b0;
        check_frame(8'h81, 1'b0, 1'b0, "rmid", -1, 5);
        @(posedge clk);
        #1;
        chk("rmid_hold/tx", tx_out, 1'b1);
        chk("rmid_hold/busy", bus.busy, 1'b0);
        rst = 1'b0;
        check_idle(3, "rmid_rel");
        accept(8'h81, 1'b1, 1'b1);
        bus.data_valid = 1'b0;
        scramble();
        check_frame(8'h81, 1'b1, 1'b1, "rmid_next", -1, -1);
        check_idle(1, "rmid_idle");

        for (int i = 0; i < 20; i++) begin
            d  = 8'($urandom);
            pe = 1'($urandom_range(0, 1));
            ty = 1'($urandom_range(0, 1));
            accept(d, pe, ty);
            bus.data_valid = 1'b0;
            scramble();
            check_frame(d, pe, ty, $sformatf("rnd%0d", i), -1, -1);
            gap = $urandom_range(0, 2);
            if (gap > 0) check_idle(gap, "rnd_idle");
        end
        check_idle(2, "end_idle");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
